// File: rtl/demux_lane_deserializer.sv
// ---------------------------------------------------------------------------
// demux_lane_deserializer
//
// Purpose:
//   Consumes the lane vector of a 1-to-N bit demux together with the select
//   that produced it. The bit on the selected lane is shifted, LSB-first, into
//   that lane's private history register. When a lane has collected WORD_W
//   bits, {channel, word} is presented on a one-deep valid/ready output stage.
//   Lanes assemble independently, so interleaved selects are legal.
//
// Ports:
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       synchronous, active-low reset
//   in_valid   in   1       lane vector + select valid this cycle
//   in_ready   out  1       block can accept a strobe (!out_valid || out_ready)
//   in_sel     in   SEL_W   select value applied to the demux for this strobe
//   in_lanes   in   LANES   demux outputs; bit in_sel carries the data bit
//   flush      in   1       clear all lane bit counters, drop same-cycle accept
//   out_valid  out  1       assembled word available
//   out_ready  in   1       consumer takes the word when out_valid && out_ready
//   out_chan   out  SEL_W   lane index the word came from
//   out_word   out  WORD_W  assembled word, first received bit in bit 0
//   sel_err    out  1       sticky lane-check error
//
// Build option:
//   DEMUX_LANE_CHECK_EN  when defined, an accepted strobe that has any lane
//                        bit set other than bit in_sel sets sel_err, sticky
//                        until reset. When undefined, sel_err is tied low.
// ---------------------------------------------------------------------------
module demux_lane_deserializer #(
    parameter int LANES  = 8,
    parameter int SEL_W  = 3,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [LANES-1:0]  in_lanes,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_chan,
    output logic [WORD_W-1:0] out_word,
    output logic              sel_err
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Only the most recent WORD_W-1 bits of a lane need storing: the final bit
    // of a word goes straight from in_lanes into the output register.
    logic [WORD_W-2:0] hist_q [LANES];
    logic [WORD_W-2:0] hist_d [LANES];
    logic [CNT_W-1:0]  cnt_q  [LANES];
    logic [CNT_W-1:0]  cnt_d  [LANES];

    out_state_t        state_q;
    out_state_t        state_d;
    logic [SEL_W-1:0]  out_chan_q;
    logic [SEL_W-1:0]  out_chan_d;
    logic [WORD_W-1:0] out_word_q;
    logic [WORD_W-1:0] out_word_d;

    logic              in_ready_s;
    logic              acc_s;
    logic              take_s;
    logic              bit_s;
    logic              last_s;
    logic              complete_s;
    logic [WORD_W-1:0] new_word_s;

    // Shift one new bit in at the MSB end of a lane's partial word.
    function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-2:0] hist,
                                                   input logic              b);
        return {b, hist};
    endfunction

    assign in_ready  = in_ready_s;
    assign out_valid = (state_q == ST_FULL);
    assign out_chan  = out_chan_q;
    assign out_word  = out_word_q;

    // Handshake decode and the selected lane's candidate word.
    always_comb begin
        in_ready_s = (state_q == ST_EMPTY) || out_ready;
        acc_s      = in_valid && in_ready_s;
        // A flush in the same cycle drops the accepted strobe entirely.
        take_s     = acc_s && !flush;
        bit_s      = in_lanes[in_sel];
        last_s     = (cnt_q[in_sel] == CNT_LAST);
        complete_s = take_s && last_s;
        new_word_s = shift_in(hist_q[in_sel], bit_s);
    end

    // Per-lane history and bit-count next state.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            hist_d[i] = hist_q[i];
            cnt_d[i]  = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (take_s && (in_sel == SEL_W'(i))) begin
                hist_d[i] = new_word_s[WORD_W-1:1];
                if (last_s) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Output stage: next state and word/channel capture.
    always_comb begin
        state_d    = state_q;
        out_chan_d = out_chan_q;
        out_word_d = out_word_q;
        case (state_q)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // While stalled in_ready is low, so no completion can occur.
                if (out_ready) begin
                    if (complete_s) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (complete_s) begin
            out_chan_d = in_sel;
            out_word_d = new_word_s;
        end else begin
            out_chan_d = out_chan_q;
            out_word_d = out_word_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_chan_q <= '0;
            out_word_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                hist_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            out_chan_q <= out_chan_d;
            out_word_q <= out_word_d;
            for (int i = 0; i < LANES; i++) begin
                hist_q[i] <= hist_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

`ifdef DEMUX_LANE_CHECK_EN
    logic sel_err_q;
    logic sel_err_d;

    // One-hot lane mask for a select value.
    function automatic logic [LANES-1:0] lane_mask(input logic [SEL_W-1:0] sel);
        logic [LANES-1:0] m;
        m      = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

    // Sticky error when any non-selected lane is active on an accepted strobe.
    always_comb begin
        sel_err_d = sel_err_q;
        if (acc_s && ((in_lanes & ~lane_mask(in_sel)) != '0)) begin
            sel_err_d = 1'b1;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
